// File: rtl/axi_slice_isolate_pkg.sv
// Shared types for the AXI slice isolation controller.
// State encoding and counter width helper.
package axi_slice_isolate_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } state_e;

  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/axi_slice_txn_counter.sv
// Saturating outstanding-transaction counter.
// Flags empty, full and decrement-at-zero.
module axi_slice_txn_counter #(
  parameter int MAX = 8,
  parameter int W   = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         is_zero_o,
  output logic         is_full_o,
  output logic         underflow_o
);

  logic [W-1:0] cnt_q;

  assign cnt_o       = cnt_q;
  assign is_zero_o   = (cnt_q == '0);
  assign is_full_o   = (cnt_q >= W'(MAX));
  assign underflow_o = dec_i & is_zero_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (inc_i & ~dec_i) begin
      cnt_q <= cnt_q + W'(1);
    end else if (dec_i & ~inc_i & ~is_zero_o) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

endmodule

// File: rtl/axi_slice_isolate_ctrl.sv
// AW/AR isolation control for an AXI register slice.
// Optional sticky underflow flag: AXI_SLICE_ISOLATE_ERR_EN.
module axi_slice_isolate_ctrl
  import axi_slice_isolate_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_WIDTH       = cnt_width(MAX_OUTSTANDING)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 isolate_i,
  output logic                 isolated_o,
  input  logic                 slv_aw_valid_i,
  output logic                 slv_aw_ready_o,
  output logic                 mst_aw_valid_o,
  input  logic                 mst_aw_ready_i,
  input  logic                 slv_ar_valid_i,
  output logic                 slv_ar_ready_o,
  output logic                 mst_ar_valid_o,
  input  logic                 mst_ar_ready_i,
  input  logic                 r_valid_i,
  input  logic                 r_ready_i,
  input  logic                 r_last_i,
  input  logic                 b_valid_i,
  input  logic                 b_ready_i,
`ifdef AXI_SLICE_ISOLATE_ERR_EN
  output logic                 err_o,
`endif
  output logic [CNT_WIDTH-1:0] aw_cnt_o,
  output logic [CNT_WIDTH-1:0] ar_cnt_o
);

  state_e state_q;
  logic   aw_pend_q;
  logic   ar_pend_q;
  logic   pass_aw;
  logic   pass_ar;
  logic   aw_hs;
  logic   ar_hs;
  logic   b_hs;
  logic   r_hs;
  logic   aw_zero;
  logic   ar_zero;
  logic   aw_full;
  logic   ar_full;
  logic   aw_uf;
  logic   ar_uf;
  logic   drained;

  // A pending valid keeps its path open so it is never withdrawn.
  assign pass_aw = aw_pend_q | ((state_q == RUN) & ~aw_full);
  assign pass_ar = ar_pend_q | ((state_q == RUN) & ~ar_full);

  assign mst_aw_valid_o = slv_aw_valid_i & pass_aw;
  assign slv_aw_ready_o = mst_aw_ready_i & pass_aw;
  assign mst_ar_valid_o = slv_ar_valid_i & pass_ar;
  assign slv_ar_ready_o = mst_ar_ready_i & pass_ar;

  assign aw_hs = mst_aw_valid_o & mst_aw_ready_i;
  assign ar_hs = mst_ar_valid_o & mst_ar_ready_i;
  assign b_hs  = b_valid_i & b_ready_i;
  assign r_hs  = r_valid_i & r_ready_i & r_last_i;

  assign drained = aw_zero & ar_zero & ~aw_pend_q & ~ar_pend_q;

  axi_slice_txn_counter #(
    .MAX (MAX_OUTSTANDING),
    .W   (CNT_WIDTH)
  ) u_aw_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_i       (aw_hs),
    .dec_i       (b_hs),
    .cnt_o       (aw_cnt_o),
    .is_zero_o   (aw_zero),
    .is_full_o   (aw_full),
    .underflow_o (aw_uf)
  );

  axi_slice_txn_counter #(
    .MAX (MAX_OUTSTANDING),
    .W   (CNT_WIDTH)
  ) u_ar_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .inc_i       (ar_hs),
    .dec_i       (r_hs),
    .cnt_o       (ar_cnt_o),
    .is_zero_o   (ar_zero),
    .is_full_o   (ar_full),
    .underflow_o (ar_uf)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_pend_q <= 1'b0;
      ar_pend_q <= 1'b0;
    end else begin
      aw_pend_q <= aw_hs ? 1'b0 : (mst_aw_valid_o | aw_pend_q);
      ar_pend_q <= ar_hs ? 1'b0 : (mst_ar_valid_o | ar_pend_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      isolated_o <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (isolate_i) state_q <= DRAIN;
          isolated_o <= 1'b0;
        end
        DRAIN: begin
          if (!isolate_i) begin
            state_q    <= RUN;
            isolated_o <= 1'b0;
          end else if (drained) begin
            state_q    <= ISOLATED;
            isolated_o <= 1'b1;
          end
        end
        ISOLATED: begin
          if (!isolate_i) begin
            state_q    <= RUN;
            isolated_o <= 1'b0;
          end
        end
        default: begin
          state_q    <= RUN;
          isolated_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXI_SLICE_ISOLATE_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if (aw_uf | ar_uf) begin
      err_o <= 1'b1;
    end
  end
`else
  logic unused_uf;
  assign unused_uf = aw_uf ^ ar_uf;
`endif

endmodule

// File: tb/tb_axi_slice_isolate_ctrl.sv
// Directed and randomized bench for axi_slice_isolate_ctrl.
module tb_axi_slice_isolate_ctrl;

  localparam int MAXO = 8;
  localparam int CW   = $clog2(MAXO + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iso;
  logic          isolated;
  logic          aw_v, aw_sr, aw_mv, aw_rdy;
  logic          ar_v, ar_sr, ar_mv, ar_rdy;
  logic          rv, rr, rl, bv, br;
  logic [CW-1:0] aw_cnt, ar_cnt;
`ifdef AXI_SLICE_ISOLATE_ERR_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  axi_slice_isolate_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .isolate_i      (iso),
    .isolated_o     (isolated),
    .slv_aw_valid_i (aw_v),
    .slv_aw_ready_o (aw_sr),
    .mst_aw_valid_o (aw_mv),
    .mst_aw_ready_i (aw_rdy),
    .slv_ar_valid_i (ar_v),
    .slv_ar_ready_o (ar_sr),
    .mst_ar_valid_o (ar_mv),
    .mst_ar_ready_i (ar_rdy),
    .r_valid_i      (rv),
    .r_ready_i      (rr),
    .r_last_i       (rl),
    .b_valid_i      (bv),
    .b_ready_i      (br),
`ifdef AXI_SLICE_ISOLATE_ERR_EN
    .err_o          (err),
`endif
    .aw_cnt_o       (aw_cnt),
    .ar_cnt_o       (ar_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference: outstanding counts, pending flags, isolation mode.
  int m_aw, m_ar;
  bit m_awp, m_arp;
  int m_mode;
  bit m_iso;
  bit m_err;
  bit m_aw_hs, m_ar_hs;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit pass_aw();
    return m_awp || (m_mode == 0 && m_aw < MAXO);
  endfunction

  function automatic bit pass_ar();
    return m_arp || (m_mode == 0 && m_ar < MAXO);
  endfunction

  task automatic model_reset();
    m_aw = 0; m_ar = 0; m_awp = 0; m_arp = 0;
    m_mode = 0; m_iso = 0; m_err = 0;
    m_aw_hs = 0; m_ar_hs = 0;
  endtask

  task automatic model_step();
    bit pw, pr, bd, rd, empty;
    pw = pass_aw();
    pr = pass_ar();
    bd = bv && br;
    rd = rv && rr && rl;
    m_aw_hs = aw_v && pw && aw_rdy;
    m_ar_hs = ar_v && pr && ar_rdy;
    empty = (m_aw == 0) && (m_ar == 0) && !m_awp && !m_arp;
    if ((bd && m_aw == 0) || (rd && m_ar == 0)) m_err = 1;
    m_aw = m_aw + int'(m_aw_hs) - int'(bd);
    m_ar = m_ar + int'(m_ar_hs) - int'(rd);
    if (m_aw < 0) m_aw = 0;
    if (m_ar < 0) m_ar = 0;
    if (m_aw_hs) m_awp = 0;
    else if (aw_v && pw) m_awp = 1;
    if (m_ar_hs) m_arp = 0;
    else if (ar_v && pr) m_arp = 1;
    if (!iso) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1 && empty) m_mode = 2;
    m_iso = (m_mode == 2);
  endtask

  task automatic tick();
    @(negedge clk);
    chk("aw_mv", aw_mv, aw_v && pass_aw());
    chk("aw_sr", aw_sr, aw_rdy && pass_aw());
    chk("ar_mv", ar_mv, ar_v && pass_ar());
    chk("ar_sr", ar_sr, ar_rdy && pass_ar());
    chk("aw_cnt", aw_cnt, m_aw);
    chk("ar_cnt", ar_cnt, m_ar);
    chk("isolated", isolated, m_iso);
`ifdef AXI_SLICE_ISOLATE_ERR_EN
    chk("err", err, m_err);
`endif
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    aw_v = 0; aw_rdy = 0; ar_v = 0; ar_rdy = 0;
    rv = 0; rr = 0; rl = 0; bv = 0; br = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 0; iso = 0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("rst_iso", isolated, 0);

    // 3 AW and 2 AR, then all returns.
    aw_v = 1; aw_rdy = 1; ar_v = 1; ar_rdy = 1;
    ticks(2);
    ar_v = 0;
    tick();
    idle();
    tick();
    chk("aw_eq3", aw_cnt, 3);
    chk("ar_eq2", ar_cnt, 2);
    bv = 1; br = 1; rv = 1; rr = 1; rl = 1;
    ticks(2);
    rv = 0;
    tick();
    idle();
    tick();
    chk("aw_eq0", aw_cnt, 0);
    chk("ar_eq0", ar_cnt, 0);

    // Fill AR to the limit, then free one slot.
    ar_v = 1; ar_rdy = 1;
    ticks(10);
    chk("ar_full", ar_cnt, MAXO);
    chk("ar_block", ar_mv, 0);
    rv = 1; rr = 1; rl = 1;
    tick();
    rv = 0;
    ticks(2);
    chk("ar_refill", ar_cnt, MAXO);
    ar_v = 0;
    rv = 1;
    ticks(MAXO);
    idle();
    tick();

    // Isolate with two writes outstanding.
    aw_v = 1; aw_rdy = 1;
    ticks(2);
    aw_v = 0;
    iso = 1;
    tick();
    aw_v = 1;
    ticks(3);
    chk("iso_blk", aw_mv, 0);
    aw_v = 0;
    bv = 1; br = 1;
    ticks(2);
    bv = 0;
    tick();
    chk("iso_on", isolated, 1);
    iso = 0;
    aw_v = 1;
    tick();
    tick();
    chk("iso_off", isolated, 0);
    aw_v = 0;
    aw_rdy = 0;
    bv = 1; br = 1;
    tick();
    idle();
    tick();

    // Pending AW when isolate rises.
    aw_v = 1; aw_rdy = 0;
    tick();
    iso = 1;
    ticks(3);
    chk("pend_hold", aw_mv, 1);
    aw_rdy = 1;
    tick();
    aw_v = 0; aw_rdy = 0;
    ticks(2);
    chk("pend_cnt", aw_cnt, 1);
    chk("pend_iso", isolated, 0);
    bv = 1; br = 1;
    tick();
    idle();
    ticks(2);
    chk("pend_done", isolated, 1);
    iso = 0;
    ticks(2);

    // Simultaneous AR handshake and R-last at count 4.
    ar_v = 1; ar_rdy = 1;
    ticks(4);
    rv = 1; rr = 1; rl = 1;
    tick();
    idle();
    tick();
    chk("ar_sim4", ar_cnt, 4);
    rv = 1; rr = 1; rl = 1;
    ticks(4);
    idle();

    // Abort in drain with one write outstanding.
    aw_v = 1; aw_rdy = 1;
    tick();
    aw_v = 0;
    iso = 1;
    ticks(2);
    iso = 0;
    tick();
    aw_v = 1;
    tick();
    chk("abort_aw", aw_cnt, 2);
    aw_v = 0;
    bv = 1; br = 1;
    ticks(3);
    idle();
    tick();

`ifdef AXI_SLICE_ISOLATE_ERR_EN
    chk("err_pre", err, 1);
`endif

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (!aw_v || m_aw_hs) aw_v = ($urandom_range(0, 2) != 0);
      if (!ar_v || m_ar_hs) ar_v = ($urandom_range(0, 2) != 0);
      aw_rdy = ($urandom_range(0, 3) != 0);
      ar_rdy = ($urandom_range(0, 3) != 0);
      bv = ($urandom_range(0, 2) == 0);
      br = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 1) == 0);
      rr = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 24) == 0) iso = !iso;
      tick();
    end

    // Reset mid-operation.
    rst_n = 0;
    #1;
    chk("mid_aw", aw_cnt, 0);
    chk("mid_ar", ar_cnt, 0);
    chk("mid_iso", isolated, 0);
    model_reset();
    idle();
    iso = 0;
    @(negedge clk);
    rst_n = 1;
    ticks(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
